seg_cell_formatter: RTL
=======================

Name: seg_cell_formatter

Overview:
- Upstream stage of the 4-digit seven-segment display driver. Converts a binary countdown/timer value (traffic-light phase time) into four 8-bit segment-pattern cells, ready to feed the driver's Cell0..Cell3 inputs.
- Binary-to-BCD conversion is sequential (iterative shift-add-3), followed by segment encoding, optional leading-zero blanking and per-digit decimal-point insertion.
- Cell outputs hold the last completed result until the next conversion completes.

Parameters:
- VAL_W, 14, width of binary input value (max representable 9999 at 14 bits)
- MAX_VAL, 9999, saturation limit; larger inputs display MAX_VAL

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- value_i  input  VAL_W  binary value to display
- load_i  input  1  request conversion of value_i; sampled only when idle
- blank_lz_i  input  1  1 = blank leading zeros (captured with load)
- dp_mask_i  input  4  decimal-point enables, bit n -> Cell n (captured with load)
- Cell0_o  output  8  units digit pattern: [6:0]=g..a active-high, [7]=dp active-high
- Cell1_o  output  8  tens digit pattern
- Cell2_o  output  8  hundreds digit pattern
- Cell3_o  output  8  thousands digit pattern
- busy_o  output  1  conversion in progress
- done_o  output  1  one-cycle pulse when cells are updated
- ovf_o  output  1  last accepted value exceeded MAX_VAL (saturated)

Behaviour:
- Reset (async, rst=1): all Cell outputs 8'h00 (blank), busy_o=0, done_o=0, ovf_o=0, FSM=IDLE, internal shift/BCD registers cleared. Reset mid-conversion aborts the conversion; no done_o is produced.
- FSM states: IDLE, CONV, ENC.
- IDLE: on the edge where load_i=1, capture min(value_i, MAX_VAL), blank_lz_i and dp_mask_i.
  - ovf_o <= (value_i > MAX_VAL).
  - Clear BCD accumulator, bit counter <= 0, busy_o <= 1, go to CONV.
- CONV: exactly VAL_W cycles. Each cycle:
  - Every BCD nibble >= 5 gets +3.
  - Shift {bcd, bin} left by 1.
  - Counter increments; after the VAL_W-th shift go to ENC.
- ENC: one cycle. Register the encoded cells, pulse done_o=1 for exactly one cycle, busy_o <= 0, return to IDLE.
- Latency: load accepted at edge k; cells and done_o change at edge k+VAL_W+1 (15 for default). busy_o is high from edge k+1 through edge k+VAL_W+1 exclusive.
- load_i while busy_o=1: ignored, no queuing, no effect on the result in progress. load_i in the ENC cycle is also ignored. A load held high re-triggers on the first IDLE cycle.
- ovf_o is held until the next accepted load.
- Segment encoding (active-high, bit0=a..bit6=g):
  - 0:7'h3F, 1:7'h06, 2:7'h5B, 3:7'h4F, 4:7'h66
  - 5:7'h6D, 6:7'h7D, 7:7'h07, 8:7'h7F, 9:7'h6F
  - Any non-decimal nibble: 7'h40 (dash). This is unreachable with saturation but still required.
- Leading-zero blanking (blank_lz=1): Cell3..Cell1 segment bits forced to 0 while that digit and all higher digits are zero. Cell0 is never blanked, so value 0 shows "0".
- Decimal point: Cell n [7] = dp_mask[n]. It is applied even on blanked digits.
- Cell outputs change only in ENC; they are stable at all other times, including during CONV.

Test Plan:
- Reset then idle -> all cells 8'h00, busy_o=0, done_o=0, ovf_o=0.
- load value_i=1234, blank_lz=0, dp_mask=0 -> done_o exactly 15 cycles after load edge. Cell3=8'h06, Cell2=8'h5B, Cell1=8'h4F, Cell0=8'h66.
- load value_i=7, blank_lz=1, dp_mask=4'b0010 -> Cell3=8'h00, Cell2=8'h00, Cell1=8'h80, Cell0=8'h07.
- load value_i=0, blank_lz=1 -> Cell0=8'h3F, others 8'h00. Then load value_i=12000 -> ovf_o=1, cells show 9999 (all 8'h6F). Next load of 5 -> ovf_o=0.
- load 4321, assert load 5555 at cycle 5 of CONV -> result is 4321 only, single done_o. Then load 5555 -> all cells 8'h6D.
- load 8888, assert rst at cycle 8 of CONV -> cells 8'h00 immediately, no done_o. After release, load 8888 -> all cells 8'h7F after 15 cycles.

Source files
------------

// File: rtl/seg_cell_formatter_if.sv
// Bus bundle between a timer source and the seven-segment cell formatter.
// The master drives the value/load side; the slave returns cell patterns and status.
interface seg_cell_formatter_if #(
  parameter int VAL_W = 14
);
  logic [VAL_W-1:0] value_i;
  logic             load_i;
  logic             blank_lz_i;
  logic [3:0]       dp_mask_i;
  logic [7:0]       Cell0_o;
  logic [7:0]       Cell1_o;
  logic [7:0]       Cell2_o;
  logic [7:0]       Cell3_o;
  logic             busy_o;
  logic             done_o;
  logic             ovf_o;

  modport master (
    output value_i, load_i, blank_lz_i, dp_mask_i,
    input  Cell0_o, Cell1_o, Cell2_o, Cell3_o, busy_o, done_o, ovf_o
  );

  modport slave (
    input  value_i, load_i, blank_lz_i, dp_mask_i,
    output Cell0_o, Cell1_o, Cell2_o, Cell3_o, busy_o, done_o, ovf_o
  );
endinterface

// File: rtl/seg_cell_formatter.sv
// Binary timer value -> four seven-segment cells (sequential double-dabble,
// then segment encode with optional leading-zero blanking and decimal points).
module seg_cell_formatter #(
  parameter int VAL_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input logic                clk,
  input logic                rst,
  seg_cell_formatter_if.slave bus
);

  localparam int               BCD_W   = 16;
  localparam int               CNT_W   = $clog2(VAL_W + 1);
  localparam logic [VAL_W-1:0] MAX_LIM = VAL_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(VAL_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    ENC
  } state_t;

  state_t           state;
  logic [VAL_W-1:0] bin_p0;
  logic [BCD_W-1:0] bcd_p0;
  logic [CNT_W-1:0] cnt;
  logic             blank_lz_p0;
  logic [3:0]       dp_mask_p0;

  logic [BCD_W-1:0] bcd_adj;
  logic [7:0]       cell0_nxt;
  logic [7:0]       cell1_nxt;
  logic [7:0]       cell2_nxt;
  logic [7:0]       cell3_nxt;

  function automatic logic [VAL_W-1:0] sat_val(input logic [VAL_W-1:0] v);
    return (v > MAX_LIM) ? MAX_LIM : v;
  endfunction

  // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] make_cell(input logic [3:0] d, input logic blank,
                                           input logic dp);
    return {dp, blank ? 7'h00 : seg7(d)};
  endfunction

  // Encode stage: a digit blanks only when it and every higher digit are zero.
  always_comb begin
    logic z3, z2, z1;
    bcd_adj   = add3(bcd_p0);
    z3        = (bcd_p0[15:12] == 4'd0);
    z2        = z3 && (bcd_p0[11:8] == 4'd0);
    z1        = z2 && (bcd_p0[7:4] == 4'd0);
    cell3_nxt = make_cell(bcd_p0[15:12], blank_lz_p0 && z3, dp_mask_p0[3]);
    cell2_nxt = make_cell(bcd_p0[11:8],  blank_lz_p0 && z2, dp_mask_p0[2]);
    cell1_nxt = make_cell(bcd_p0[7:4],   blank_lz_p0 && z1, dp_mask_p0[1]);
    cell0_nxt = make_cell(bcd_p0[3:0],   1'b0,              dp_mask_p0[0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bin_p0      <= '0;
      bcd_p0      <= '0;
      cnt         <= '0;
      blank_lz_p0 <= 1'b0;
      dp_mask_p0  <= 4'h0;
      bus.Cell0_o <= 8'h00;
      bus.Cell1_o <= 8'h00;
      bus.Cell2_o <= 8'h00;
      bus.Cell3_o <= 8'h00;
      bus.busy_o  <= 1'b0;
      bus.done_o  <= 1'b0;
      bus.ovf_o   <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_i) begin
            bin_p0      <= sat_val(bus.value_i);
            blank_lz_p0 <= bus.blank_lz_i;
            dp_mask_p0  <= bus.dp_mask_i;
            bus.ovf_o   <= (bus.value_i > MAX_LIM);
            bcd_p0      <= '0;
            cnt         <= '0;
            bus.busy_o  <= 1'b1;
            state       <= CONV;
          end
        end
        // Conversion stage: one shift per cycle, VAL_W shifts in total.
        CONV: begin
          {bcd_p0, bin_p0} <= {bcd_adj[BCD_W-2:0], bin_p0, 1'b0};
          cnt              <= cnt + CNT_W'(1);
          if (cnt == LAST)
            state <= ENC;
        end
        ENC: begin
          bus.Cell0_o <= cell0_nxt;
          bus.Cell1_o <= cell1_nxt;
          bus.Cell2_o <= cell2_nxt;
          bus.Cell3_o <= cell3_nxt;
          bus.done_o  <= 1'b1;
          bus.busy_o  <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
